// File: rtl/acc_datapath_seq.sv
// Parametrised accumulator datapath (IR, PC, AC, adder) with its own fetch/execute sequencer and req/ack memory port.
// Optional: define ACC_DATAPATH_COND_JMP_EN to turn opcode 11 into JZ (branch only when AC==0).
module acc_datapath_seq #(
    parameter int                 DATA_W   = 8,
    parameter int                 ADR_W    = 6,
    parameter logic [ADR_W-1:0]   RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              mem_req,
    output logic              mem_we,
    input  logic              mem_ack,
    output logic [ADR_W-1:0]  adr_bus,
    input  logic [DATA_W-1:0] data_bus_in,
    output logic [DATA_W-1:0] data_bus_out,
    output logic [1:0]        op_code,
    output logic [ADR_W-1:0]  pc_out,
    output logic [DATA_W-1:0] ac_out,
    output logic              carry,
    output logic              zero,
    output logic [1:0]        state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    localparam logic [1:0] OP_LDA = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_STA = 2'b10;

    state_t            state_reg, state_next;
    logic [ADR_W-1:0]  pc_reg, pc_next;
    logic [1:0]        op_reg, op_next;
    logic [ADR_W-1:0]  operand_reg, operand_next;
    logic [DATA_W-1:0] ac_reg, ac_next;
    logic              carry_reg, carry_next;
    logic              done;

    // Only the opcode and operand fields of IR are kept; the bits between them never affect behaviour.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            pc_reg      <= RESET_PC;
            op_reg      <= '0;
            operand_reg <= '0;
            ac_reg      <= '0;
            carry_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            op_reg      <= op_next;
            operand_reg <= operand_next;
            ac_reg      <= ac_next;
            carry_reg   <= carry_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        op_next      = op_reg;
        operand_next = operand_reg;
        ac_next      = ac_reg;
        carry_next   = carry_reg;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        adr_bus      = pc_reg;
        done         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (run) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    op_next      = data_bus_in[DATA_W-1 -: 2];
                    operand_next = data_bus_in[ADR_W-1:0];
                    pc_next      = pc_reg + ADR_W'(1);
                    state_next   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                adr_bus = operand_reg;
                case (op_reg)
                    OP_LDA: begin
                        mem_req = 1'b1;
                        if (mem_ack) begin
                            ac_next = data_bus_in;
                            done    = 1'b1;
                        end
                    end
                    OP_ADD: begin
                        mem_req = 1'b1;
                        if (mem_ack) begin
                            {carry_next, ac_next} = {1'b0, ac_reg} + {1'b0, data_bus_in};
                            done = 1'b1;
                        end
                    end
                    OP_STA: begin
                        mem_req = 1'b1;
                        mem_we  = 1'b1;
                        if (mem_ack) done = 1'b1;
                    end
                    default: begin
`ifdef ACC_DATAPATH_COND_JMP_EN
                        if (ac_reg == '0) pc_next = operand_reg;
`else
                        pc_next = operand_reg;
`endif
                        done = 1'b1;
                    end
                endcase
                // run is sampled only at instruction end, so a dropped run lets the current one finish.
                if (done) state_next = run ? ST_FETCH : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign data_bus_out = ac_reg;
    assign op_code      = op_reg;
    assign pc_out       = pc_reg;
    assign ac_out       = ac_reg;
    assign carry        = carry_reg;
    assign zero         = (ac_reg == '0);
    assign state_o      = state_reg;

endmodule

// File: tb/tb_acc_datapath_seq.sv
// Self-checking bench for acc_datapath_seq: directed program steps plus random programs checked against an ISA-level model.
module tb_acc_datapath_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       run;
    logic       mem_req;
    logic       mem_we;
    logic       mem_ack;
    logic [5:0] adr_bus;
    logic [7:0] data_bus_in;
    logic [7:0] data_bus_out;
    logic [1:0] op_code;
    logic [5:0] pc_out;
    logic [7:0] ac_out;
    logic       carry;
    logic       zero;
    logic [1:0] state_o;

    acc_datapath_seq #(.DATA_W(8), .ADR_W(6), .RESET_PC(6'd0)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_ack     (mem_ack),
        .adr_bus     (adr_bus),
        .data_bus_in (data_bus_in),
        .data_bus_out(data_bus_out),
        .op_code     (op_code),
        .pc_out      (pc_out),
        .ac_out      (ac_out),
        .carry       (carry),
        .zero        (zero),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory seen by the DUT, and the model's own copy of architectural state.
    logic [7:0] tb_mem    [64];
    logic [7:0] model_mem [64];
    int m_pc, m_ac, m_carry;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input int a, input int d);
        tb_mem[a]    = 8'(d);
        model_mem[a] = 8'(d);
    endtask

    // Serve one request: w wait cycles, then a one-cycle ack; request attributes must stay stable.
    task automatic mem_phase(input int w, input int exp_adr, input bit exp_we, input int exp_state);
        for (int i = 0; i <= w; i++) begin
            chk("state_hold", state_o, exp_state);
            chk("mem_req", mem_req, 1);
            chk("mem_we", mem_we, exp_we);
            chk("adr_bus", adr_bus, exp_adr);
            if (i == w) begin
                mem_ack = 1'b1;
                if (exp_we) tb_mem[exp_adr] = data_bus_out;
                else        data_bus_in = tb_mem[exp_adr];
            end else begin
                data_bus_in = 8'($urandom);
            end
            @(negedge clk);
        end
        mem_ack     = 1'b0;
        data_bus_in = 8'($urandom);
    endtask

    // Run one instruction starting at a negedge in FETCH; model steps the ISA and all state is compared afterwards.
    task automatic exec_one(input int wf, input int wex, input bit drop_run);
        int instr, op, opd, sum;
        instr = model_mem[m_pc];
        op    = instr / 64;
        opd   = instr % 64;
        mem_phase(wf, m_pc, 1'b0, 1);
        m_pc = (m_pc + 1) % 64;
        chk("fetch_to_exec", state_o, 2);
        chk("op_code", op_code, op);
        chk("pc_incr", pc_out, m_pc);
        if (drop_run) run = 1'b0;
        case (op)
            0: begin
                mem_phase(wex, opd, 1'b0, 2);
                m_ac = model_mem[opd];
            end
            1: begin
                mem_phase(wex, opd, 1'b0, 2);
                sum     = m_ac + model_mem[opd];
                m_carry = (sum > 255) ? 1 : 0;
                m_ac    = sum % 256;
            end
            2: begin
                mem_phase(wex, opd, 1'b1, 2);
                model_mem[opd] = 8'(m_ac);
            end
            default: begin
                chk("jmp_no_req", mem_req, 0);
                mem_ack     = 1'($urandom_range(0, 1));
                data_bus_in = 8'($urandom);
                @(negedge clk);
                mem_ack = 1'b0;
`ifdef ACC_DATAPATH_COND_JMP_EN
                if (m_ac == 0) m_pc = opd;
`else
                m_pc = opd;
`endif
            end
        endcase
        chk("exit_state", state_o, drop_run ? 0 : 1);
        chk("pc", pc_out, m_pc);
        chk("ac", ac_out, m_ac);
        chk("carry", carry, m_carry);
        chk("zero", zero, (m_ac == 0) ? 1 : 0);
        chk("data_bus_out", data_bus_out, m_ac);
        if (op == 2) chk("sta_mem", tb_mem[opd], model_mem[opd]);
        $display("instr %02h op=%0d opd=%02h wf=%0d wex=%0d -> pc=%02h ac=%02h c=%0d z=%0d st=%0d",
                 instr, op, opd, wf, wex, pc_out, ac_out, carry, zero, state_o);
    endtask

    // Sit in IDLE (ack pulses must be ignored), then restart with run.
    task automatic resume(input int idle);
        for (int i = 0; i < idle; i++) begin
            chk("idle_state", state_o, 0);
            chk("idle_req", mem_req, 0);
            chk("idle_pc", pc_out, m_pc);
            chk("idle_ac", ac_out, m_ac);
            mem_ack     = 1'b1;
            data_bus_in = 8'($urandom);
            @(negedge clk);
        end
        mem_ack = 1'b0;
        run     = 1'b1;
        @(negedge clk);
        chk("resume_fetch", state_o, 1);
        $display("resume after %0d idle cycles: pc=%02h st=%0d", idle, pc_out, state_o);
    endtask

    // Asynchronous reset asserted mid-cycle while a fetch request is outstanding.
    task automatic reset_mid();
        chk("pre_reset_req", mem_req, 1);
        #2 rst = 1'b0;
        #1;
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_state", state_o, 0);
        chk("rst_pc", pc_out, 0);
        chk("rst_ac", ac_out, 0);
        chk("rst_zero", zero, 1);
        chk("rst_carry", carry, 0);
        chk("rst_op", op_code, 0);
        $display("mid-cycle reset: req=%0d st=%0d pc=%02h", mem_req, state_o, pc_out);
        run = 1'b0;
        @(negedge clk);
        rst  = 1'b1;
        m_pc = 0; m_ac = 0; m_carry = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; run = 1'b0; mem_ack = 1'b0; data_bus_in = 8'h00;
        m_pc = 0; m_ac = 0; m_carry = 0;
        for (int i = 0; i < 64; i++) poke(i, 0);
        @(negedge clk);
        chk("reset_state", state_o, 0);
        chk("reset_pc", pc_out, 0);
        chk("reset_ac", ac_out, 0);
        chk("reset_zero", zero, 1);
        chk("reset_carry", carry, 0);
        chk("reset_req", mem_req, 0);
        rst = 1'b1;
        @(negedge clk);

        // Directed program: LDA/ADD/STA, overflow with waits, JMP and PC wrap.
        poke(0, 8'h0A); poke(1, 8'h4B); poke(2, 8'h8C);
        poke(3, 8'h0D); poke(4, 8'h4E); poke(5, 8'hFF);
        poke(10, 8'h05); poke(11, 8'h07);
        poke(13, 8'hF0); poke(14, 8'h20); poke(15, 8'h00);
        poke(63, 8'h0F);
        resume(2);
        exec_one(0, 0, 1'b0);
        exec_one(0, 0, 1'b0);
        exec_one(0, 0, 1'b0);
        chk("tp_mem12", tb_mem[12], 8'h0C);
        chk("tp_carry0", carry, 0);
        chk("tp_pc3", pc_out, 3);
        exec_one(3, 3, 1'b0);
        exec_one(3, 3, 1'b0);
        chk("ovf_ac", ac_out, 8'h10);
        chk("ovf_carry", carry, 1);
        chk("ovf_zero", zero, 0);
        exec_one(0, 0, 1'b0);
        chk("jmp_pc", pc_out, 6'h3F);
        exec_one(1, 0, 1'b0);
        chk("wrap_pc", pc_out, 0);
        exec_one(0, 0, 1'b0);
        exec_one(0, 2, 1'b1);
        chk("runoff_state", state_o, 0);
        chk("runoff_pc", pc_out, 2);
        chk("runoff_ac", ac_out, 8'h0C);
        resume(1);
        reset_mid();

        // Opcode 11 as JMP or JZ depending on build.
        for (int i = 0; i < 64; i++) poke(i, 0);
        poke(0, 8'h0F); poke(1, 8'hD4); poke(15, 8'h00);
        poke(20, 8'h10); poke(21, 8'hDE); poke(16, 8'h01);
        resume(0);
        exec_one(0, 0, 1'b0);
        exec_one(0, 0, 1'b0);
        chk("jz_taken_pc", pc_out, 20);
        exec_one(0, 1, 1'b0);
        exec_one(0, 0, 1'b0);
`ifdef ACC_DATAPATH_COND_JMP_EN
        chk("jz_not_taken_pc", pc_out, 22);
`else
        chk("jmp_uncond_pc", pc_out, 30);
`endif
        reset_mid();

        // Random programs, random wait states and random run drops.
        for (int i = 0; i < 64; i++) poke(i, $urandom);
        resume(0);
        for (int n = 0; n < 150; n++) begin
            bit drop;
            drop = ($urandom_range(0, 7) == 0);
            exec_one($urandom_range(0, 3), $urandom_range(0, 3), drop);
            if (drop) resume($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
